leitor_teclado: RTL and testbench

Matrix keypad scanner for the vending machine front panel. It is the input-side counterpart of the multiplexed 7-segment display driver. It strobes one keypad column at a time, low-active, and reads the row lines back. It debounces a single key across whole scan frames and delivers a one-cycle key event with a code. That event feeds the drink-select/confirm logic upstream of the display decoder.

---
 rtl/teclado_pkg.sv | 25 ++
 rtl/varredura_colunas.sv | 34 +++
 rtl/leitor_teclado.sv | 161 ++++++++++++++++
 tb/tb_leitor_teclado.sv | 133 +++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: shared types and helpers
// for the front-panel keypad scanner.
package teclado_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM,
      HELD,
      RELEASE
   } estado_t;

   localparam int NUM_COL = 4;
   localparam int NUM_LIN = 3;
   localparam int CODE_W  = 4;

   // key code = col*3 + row, 0..11
   function automatic logic [CODE_W-1:0] code(
      input logic [1:0] col,
      input logic [1:0] row
   );
      return CODE_W'(col) * CODE_W'(NUM_LIN)
           + CODE_W'(row);
   endfunction

endpackage

// File: rtl/varredura_colunas.sv
// varredura_colunas: slot divider and
// low-active column strobe generator.
module varredura_colunas #(
   parameter int DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] col,
   output logic [3:0] coluna,
   output logic       amostra
);

   localparam int DW = $clog2(DIV);

   logic [DW-1:0] div;

   assign amostra = (div == DW'(DIV - 1));

   // divider, column index and strobes advance together
   always_ff @(posedge clk) begin
      if (rst) begin
         div    <= '0;
         col    <= '0;
         coluna <= 4'b1110;
      end else if (amostra) begin
         div    <= '0;
         col    <= col + 2'd1;
         coluna <= ~(4'b0001 << (col + 2'd1));
      end else begin
         div    <= div + 1'b1;
      end
   end

endmodule

// File: rtl/leitor_teclado.sv
// leitor_teclado: 4x3 keypad scanner with
// frame-level debounce and one-cycle key events.
module leitor_teclado
   import teclado_pkg::*;
#(
   parameter int DIV = 50000,
   parameter int DEB = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] linha,
   output logic [3:0] coluna,
   output logic [3:0] tecla,
   output logic       tecla_valida,
   output logic       tecla_pressionada
);

   localparam int CW = $clog2(DEB + 1);
   localparam logic [CW-1:0] DEB_C = CW'(DEB);
   localparam logic [CW-1:0] UM    = CW'(1);

   logic [1:0]        col;
   logic              amostra;
   logic [2:0]        s1, s2;
   logic              vazio;
   logic [1:0]        lin;
   logic [CODE_W-1:0] cod;

   estado_t           estado, estado_n;
   logic [CW-1:0]     cnt, cnt_n, cnt_inc;
   logic [CODE_W-1:0] cand, cand_n;
   logic [1:0]        ccol, ccol_n;
   logic [CODE_W-1:0] tecla_n;
   logic              valida_n;
   logic              casa, mesma_col;

   varredura_colunas #(.DIV(DIV)) u_varr (
      .clk     (clk),
      .rst     (rst),
      .col     (col),
      .coluna  (coluna),
      .amostra (amostra)
   );

   // two-flop synchronizer for the async rows
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 3'b111;
         s2 <= 3'b111;
      end else begin
         s1 <= linha;
         s2 <= s1;
      end
   end

   // lowest low row wins
   always_comb begin
      vazio = &s2;
      lin   = 2'd2;
      if (!s2[0])      lin = 2'd0;
      else if (!s2[1]) lin = 2'd1;
   end

   assign cod       = code(col, lin);
   assign casa      = !vazio && (cod == cand);
   assign mesma_col = (col == ccol);
   assign cnt_inc   = (cnt == DEB_C) ? cnt : cnt + UM;

   // debounce FSM: evaluated only on sample strobes
   always_comb begin
      estado_n = estado;
      cnt_n    = cnt;
      cand_n   = cand;
      ccol_n   = ccol;
      tecla_n  = tecla;
      valida_n = 1'b0;
      if (amostra) begin
         unique case (estado)
            IDLE: begin
               if (!vazio) begin
                  cand_n = cod;
                  ccol_n = col;
                  if (DEB == 1) begin
                     tecla_n  = cod;
                     valida_n = 1'b1;
                     cnt_n    = '0;
                     estado_n = HELD;
                  end else begin
                     cnt_n    = UM;
                     estado_n = CONFIRM;
                  end
               end
            end
            CONFIRM: begin
               if (mesma_col) begin
                  if (casa) begin
                     cnt_n = cnt_inc;
                     if (cnt_inc == DEB_C) begin
                        tecla_n  = cand;
                        valida_n = 1'b1;
                        cnt_n    = '0;
                        estado_n = HELD;
                     end
                  end else begin
                     cnt_n    = '0;
                     estado_n = IDLE;
                  end
               end
            end
            HELD: begin
               if (mesma_col && !casa) begin
                  if (DEB == 1) begin
                     cnt_n    = '0;
                     estado_n = IDLE;
                  end else begin
                     cnt_n    = UM;
                     estado_n = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (mesma_col) begin
                  if (casa) begin
                     cnt_n    = '0;
                     estado_n = HELD;
                  end else if (cnt_inc == DEB_C) begin
                     cnt_n    = '0;
                     estado_n = IDLE;
                  end else begin
                     cnt_n    = cnt_inc;
                  end
               end
            end
            default: estado_n = IDLE;
         endcase
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         estado            <= IDLE;
         cnt               <= '0;
         cand              <= '0;
         ccol              <= '0;
         tecla             <= '0;
         tecla_valida      <= 1'b0;
         tecla_pressionada <= 1'b0;
      end else begin
         estado            <= estado_n;
         cnt               <= cnt_n;
         cand              <= cand_n;
         ccol              <= ccol_n;
         tecla             <= tecla_n;
         tecla_valida      <= valida_n;
         tecla_pressionada <= (estado_n == HELD) ||
                              (estado_n == RELEASE);
      end
   end

endmodule

// File: tb/tb_leitor_teclado.sv
// tb_leitor_teclado: frame-aligned directed
// vectors against a behavioural keypad.
module tb_leitor_teclado;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] linha;
   logic [3:0] coluna;
   logic [3:0] tecla;
   logic       tecla_valida;
   logic       tecla_pressionada;
   logic [11:0] teclas;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [11:0] mask;
      int          frames;
      bit          do_rst;
      int          pulsos;
      int          tecla;
      int          press;
   } vec_t;

   vec_t tab[15];

   leitor_teclado #(.DIV(4), .DEB(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .linha             (linha),
      .coluna            (coluna),
      .tecla             (tecla),
      .tecla_valida      (tecla_valida),
      .tecla_pressionada (tecla_pressionada)
   );

   always #5 clk = ~clk;

   // keypad: pressed key pulls its row low when its column is strobed
   always_comb begin
      linha = 3'b111;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 3; r++)
            if (teclas[c*3+r] && !coluna[c])
               linha[r] = 1'b0;
   end

   task automatic check(input string nome,
                        input int got,
                        input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d",
                  nome, got, exp);
      end
   endtask

   task automatic aplica_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst coluna", int'(coluna), 14);
      check("rst tecla", int'(tecla), 0);
      check("rst valida", int'(tecla_valida), 0);
      check("rst press", int'(tecla_pressionada), 0);
      rst = 1'b0;
   endtask

   task automatic run_frames(input int f,
                             output int pulsos);
      pulsos = 0;
      repeat (f * 16) begin
         @(posedge clk);
         @(negedge clk);
         if (tecla_valida) pulsos++;
      end
   endtask

   initial begin
      int p;
      logic [3:0] um;
      logic [3:0] exp_c;
      string nm;

      tab[0]  = '{12'h004, 2, 1'b0, 0, 0,  0};
      tab[1]  = '{12'h000, 2, 1'b0, 0, 0,  0};
      tab[2]  = '{12'h080, 5, 1'b0, 1, 7,  1};
      tab[3]  = '{12'h000, 3, 1'b0, 0, 7,  0};
      tab[4]  = '{12'h808, 4, 1'b0, 1, 3,  1};
      tab[5]  = '{12'h80A, 2, 1'b0, 0, 3,  1};
      tab[6]  = '{12'h802, 3, 1'b0, 0, 3,  0};
      tab[7]  = '{12'h802, 3, 1'b0, 1, 11, 1};
      tab[8]  = '{12'h000, 3, 1'b0, 0, 11, 0};
      tab[9]  = '{12'h140, 3, 1'b0, 1, 6,  1};
      tab[10] = '{12'h000, 3, 1'b0, 0, 6,  0};
      tab[11] = '{12'h010, 2, 1'b0, 0, 6,  0};
      tab[12] = '{12'h010, 2, 1'b1, 0, 0,  0};
      tab[13] = '{12'h010, 1, 1'b0, 1, 4,  1};
      tab[14] = '{12'h000, 3, 1'b0, 0, 4,  0};

      teclas = '0;
      rst    = 1'b1;
      aplica_reset();

      um = 4'b0001;
      for (int s = 0; s < 4; s++) begin
         repeat (4) begin
            @(posedge clk);
            @(negedge clk);
         end
         exp_c = ~(um << ((s + 1) % 4));
         check("col cycle", int'(coluna), int'(exp_c));
      end

      for (int i = 0; i < 15; i++) begin
         teclas = tab[i].mask;
         if (tab[i].do_rst) aplica_reset();
         run_frames(tab[i].frames, p);
         nm = $sformatf("v%0d", i);
         check({nm, " pulses"}, p, tab[i].pulsos);
         check({nm, " tecla"}, int'(tecla), tab[i].tecla);
         check({nm, " press"},
               int'(tecla_pressionada), tab[i].press);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
